eight_input_frame_loader: RTL and testbench
===========================================

Name: eight_input_frame_loader

Overview:
- Upstream input stage for the eight-input muxed-output function block.
- Receives one serial frame (mode bit, 8 data bits, optional parity bit) under a valid strobe and checks parity.
- Presents the frame as a stable parallel vector a..h plus the comb/seq select.
- Outputs change only on a complete, parity-clean frame, so the downstream function sees glitch-free, atomic updates.

Parameters:
- DATA_W, 8, number of parallel data bits; bit DATA_W-1 drives input a, bit 0 drives input h.
- PARITY_EN, 1, 1 = frame carries a trailing parity bit that is checked; 0 = no parity bit.
- ODD_PARITY, 0, 0 = even parity over {mode, data, parity}; 1 = odd parity.
- TIMEOUT, 16, maximum idle cycles allowed between accepted bits inside a frame.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- frame_start  input  1  single-cycle pulse that begins a new frame.
- ser_in  input  1  serial data bit, sampled when ser_valid=1.
- ser_valid  input  1  qualifies ser_in; one bit accepted per cycle.
- data_out  output  DATA_W  registered parallel data (a..h, MSB first).
- sel_out  output  1  registered mode bit (0 = combinational path, 1 = sequential path).
- frame_valid  output  1  one-cycle pulse when data_out/sel_out have just been updated.
- parity_err  output  1  one-cycle pulse when a frame is rejected on parity.
- timeout_err  output  1  one-cycle pulse when a frame is abandoned on timeout.
- busy  output  1  high in SHIFT and CHECK.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; data_out=0; sel_out=0; all pulses=0; busy=0; counters=0.
  - Deassertion is synchronous to clk.
- Frame format, bit order of accepted bits:
  - mode bit first, then data MSB..LSB, then parity if PARITY_EN.
  - FRAME_LEN = 1 + DATA_W + PARITY_EN (10 by default).
- FSM states: IDLE, SHIFT, CHECK.
- IDLE:
  - ser_valid is ignored.
  - frame_start=1 -> SHIFT; bit_cnt=0; gap_cnt=0; shift register cleared.
  - frame_start has priority: a ser_valid in the same cycle is not captured.
- SHIFT:
  - On each ser_valid=1: shift ser_in into the shift register; bit_cnt++; gap_cnt=0.
  - On each ser_valid=0: gap_cnt++.
  - When the accepted bit is number FRAME_LEN (bit_cnt==FRAME_LEN-1 at that edge) -> CHECK.
  - When gap_cnt reaches TIMEOUT -> IDLE; pulse timeout_err for 1 cycle; outputs hold.
  - frame_start=1 in SHIFT restarts the frame: counters cleared, no error pulse, stays in SHIFT; ser_valid that cycle is ignored.
- CHECK (exactly 1 cycle):
  - Parity ok = XOR over all FRAME_LEN bits equals ODD_PARITY.
  - If ok: data_out/sel_out load from the shift register and frame_valid pulses.
  - If not ok: outputs hold and parity_err pulses.
  - PARITY_EN=0: always ok.
  - Always -> IDLE.
  - frame_start in CHECK is ignored.
- Latency:
  - Last bit accepted at edge N.
  - data_out, sel_out and frame_valid are visible after edge N+1.
  - Earliest next frame_start is honoured at edge N+2.
- Pulses:
  - frame_valid, parity_err and timeout_err are mutually exclusive and never high for more than 1 cycle.
- Stability:
  - data_out/sel_out change only together with frame_valid.
- Widths:
  - bit_cnt width = clog2(FRAME_LEN+1).
  - gap_cnt width = clog2(TIMEOUT+1); gap_cnt saturates and does not wrap.
- Reset mid-frame: partial frame discarded; outputs return to reset values.

Decomposition:
- Shared package: state enum (IDLE, SHIFT, CHECK) and the FRAME_LEN derivation function.
- One natural sub-module: frame_parity_check, a combinational XOR reduce over FRAME_LEN bits with ODD_PARITY.
- Everything else lives in the top FSM.

Test Plan:
- Reset value: assert rst_n=0 mid-SHIFT -> data_out=8'h00, sel_out=0, busy=0 immediately; no pulses after release.
- Good frame, even parity: send mode=1, data=8'hA5, parity=1 on 10 consecutive cycles -> edge after CHECK gives data_out=8'hA5, sel_out=1, frame_valid high for 1 cycle.
- Bad parity: send mode=0, data=8'h3C, parity=1 -> parity_err 1 cycle; data_out/sel_out keep the previous 8'hA5/1.
- Timeout: frame_start then 4 bits, then ser_valid=0 for 16 cycles -> timeout_err on the 16th idle cycle; state returns to IDLE; outputs unchanged.
- Restart: frame_start again after 5 bits, then a full frame 0,8'hFF,0 -> only one frame_valid; data_out=8'hFF, sel_out=0; no error pulses.
- Gaps and priority: frame_start and ser_valid together in IDLE -> that bit ignored. A good frame 1,8'h01,0 with 1-3 cycle gaps between bits -> data_out=8'h01, sel_out=1.

Source files
------------

// File: rtl/eight_input_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eight_input_frame_loader_pkg
// Brief    : Shared FSM state type and frame-length derivation for the loader.
// Revision : 1.0 - initial release
// ============================================================================
package eight_input_frame_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Mode bit + data bits + optional trailing parity bit.
    function automatic int unsigned frame_len(input int unsigned data_w, input bit parity_en);
        return 1 + data_w + (parity_en ? 1 : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/eight_input_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : eight_input_frame_loader_if
// Brief    : Serial-frame input and parallel-vector output bundle of the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface eight_input_frame_loader_if #(
    parameter int unsigned DATA_W = 8
);
    logic              frame_start;
    logic              ser_in;
    logic              ser_valid;
    logic [DATA_W-1:0] data_out;
    logic              sel_out;
    logic              frame_valid;
    logic              parity_err;
    logic              timeout_err;
    logic              busy;

    modport master (
        output frame_start, ser_in, ser_valid,
        input  data_out, sel_out, frame_valid, parity_err, timeout_err, busy
    );

    modport slave (
        input  frame_start, ser_in, ser_valid,
        output data_out, sel_out, frame_valid, parity_err, timeout_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/eight_input_frame_loader_frame_parity_check.sv
`default_nettype none
// ============================================================================
// Module   : frame_parity_check
// Brief    : XOR-reduce of a captured frame against the selected parity sense.
// Revision : 1.0 - initial release
// ============================================================================
module frame_parity_check #(
    parameter int unsigned FRAME_LEN  = 10,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  wire logic [FRAME_LEN-1:0] frame,
    output logic                      parity_ok
);
    assign parity_ok = PARITY_EN ? ((^frame) == ODD_PARITY) : 1'b1;
endmodule
`default_nettype wire

// File: rtl/eight_input_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : eight_input_frame_loader
// Brief    : Serial frame receiver presenting a parity-checked, atomically
//            updated parallel vector a..h plus comb/seq select.
// Revision : 1.0 - initial release
// ============================================================================
module eight_input_frame_loader
    import eight_input_frame_loader_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          ODD_PARITY = 1'b0,
    parameter int unsigned TIMEOUT    = 16
) (
    input wire logic                  clk,
    input wire logic                  rst_n,
    eight_input_frame_loader_if.slave bus
);
    localparam int unsigned c_frame_len = frame_len(DATA_W, PARITY_EN);
    localparam int unsigned c_bit_w     = $clog2(c_frame_len + 1);
    localparam int unsigned c_gap_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(c_frame_len - 1);
    localparam logic [c_gap_w-1:0] c_timeout  = c_gap_w'(TIMEOUT);

    state_t                   r_state, w_state_nxt;
    logic [c_frame_len-1:0]   r_shift, w_shift_nxt;
    logic [c_bit_w-1:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [c_gap_w-1:0]       r_gap_cnt, w_gap_cnt_nxt, w_gap_inc;
    logic [DATA_W-1:0]        r_data, w_data_nxt;
    logic                     r_sel, w_sel_nxt;
    logic                     r_frame_valid, w_frame_valid_nxt;
    logic                     r_parity_err, w_parity_err_nxt;
    logic                     r_timeout_err, w_timeout_err_nxt;
    logic                     w_parity_ok;

    frame_parity_check #(
        .FRAME_LEN  (c_frame_len),
        .PARITY_EN  (PARITY_EN),
        .ODD_PARITY (ODD_PARITY)
    ) u_parity (
        .frame     (r_shift),
        .parity_ok (w_parity_ok)
    );

    // Saturating idle counter so it can never wrap back under the limit.
    assign w_gap_inc = (r_gap_cnt == {c_gap_w{1'b1}}) ? r_gap_cnt : r_gap_cnt + c_gap_w'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_shift_nxt       = r_shift;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_data_nxt        = r_data;
        w_sel_nxt         = r_sel;
        w_frame_valid_nxt = 1'b0;
        w_parity_err_nxt  = 1'b0;
        w_timeout_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    w_state_nxt   = ST_SHIFT;
                    w_shift_nxt   = '0;
                    w_bit_cnt_nxt = '0;
                    w_gap_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (bus.frame_start) begin
                    w_shift_nxt   = '0;
                    w_bit_cnt_nxt = '0;
                    w_gap_cnt_nxt = '0;
                end else if (bus.ser_valid) begin
                    w_shift_nxt   = {r_shift[c_frame_len-2:0], bus.ser_in};
                    w_bit_cnt_nxt = r_bit_cnt + c_bit_w'(1);
                    w_gap_cnt_nxt = '0;
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_nxt = ST_CHECK;
                    end
                end else begin
                    w_gap_cnt_nxt = w_gap_inc;
                    if (w_gap_inc == c_timeout) begin
                        w_state_nxt       = ST_IDLE;
                        w_timeout_err_nxt = 1'b1;
                        w_bit_cnt_nxt     = '0;
                        w_gap_cnt_nxt     = '0;
                    end
                end
            end
            ST_CHECK: begin
                // Mode is the oldest bit; data follows immediately below it.
                if (w_parity_ok) begin
                    w_data_nxt        = r_shift[c_frame_len-2 -: DATA_W];
                    w_sel_nxt         = r_shift[c_frame_len-1];
                    w_frame_valid_nxt = 1'b1;
                end else begin
                    w_parity_err_nxt  = 1'b1;
                end
                w_state_nxt   = ST_IDLE;
                w_bit_cnt_nxt = '0;
                w_gap_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_data        <= '0;
            r_sel         <= 1'b0;
            r_frame_valid <= 1'b0;
            r_parity_err  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_data        <= w_data_nxt;
            r_sel         <= w_sel_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_parity_err  <= w_parity_err_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.data_out    = r_data;
    assign bus.sel_out     = r_sel;
    assign bus.frame_valid = r_frame_valid;
    assign bus.parity_err  = r_parity_err;
    assign bus.timeout_err = r_timeout_err;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eight_input_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_eight_input_frame_loader
// Brief    : Directed and randomized self-checking bench for the frame loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eight_input_frame_loader;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;
    int   cnt_fv, cnt_pe, cnt_to;
    logic [7:0] exp_data;
    logic       exp_sel;

    eight_input_frame_loader_if #(.DATA_W(8)) bus ();

    eight_input_frame_loader #(
        .DATA_W     (8),
        .PARITY_EN  (1'b1),
        .ODD_PARITY (1'b0),
        .TIMEOUT    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle; tallies every output pulse seen.
    task automatic tick();
        @(posedge clk);
        #1;
        cnt_fv += int'(bus.frame_valid);
        cnt_pe += int'(bus.parity_err);
        cnt_to += int'(bus.timeout_err);
    endtask

    task automatic clear_pulse_counts();
        cnt_fv = 0; cnt_pe = 0; cnt_to = 0;
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        bus.ser_valid   = 1'b0;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [9:0] f, input int nbits, input int min_gap, input int max_gap);
        for (int i = 9; i > 9 - nbits; i--) begin
            int gap;
            gap = (max_gap > min_gap) ? int'($urandom_range(max_gap, min_gap)) : min_gap;
            bus.ser_valid = 1'b0;
            for (int g = 0; g < gap; g++) tick();
            bus.ser_valid = 1'b1;
            bus.ser_in    = f[i];
            tick();
        end
        bus.ser_valid = 1'b0;
    endtask

    // Model: frame accepted iff total even parity over all ten bits.
    task automatic finish_frame(input string tag, input logic [9:0] f);
        logic ok;
        ok = ((^f) == 1'b0);
        check({tag, "_busy_in_check"}, 32'(bus.busy), 32'd1);
        tick();
        if (ok) begin
            exp_data = f[8:1];
            exp_sel  = f[9];
        end
        check({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'(ok));
        check({tag, "_parity_err"}, 32'(bus.parity_err), 32'(!ok));
        check({tag, "_data_out"}, 32'(bus.data_out), 32'(exp_data));
        check({tag, "_sel_out"}, 32'(bus.sel_out), 32'(exp_sel));
        tick();
        check({tag, "_pulse_drop"}, 32'({bus.frame_valid, bus.parity_err, bus.timeout_err}), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [9:0] f;
        n_checks = 0; n_pass = 0; n_fail = 0;
        clear_pulse_counts();
        exp_data = 8'h00; exp_sel = 1'b0;
        bus.frame_start = 1'b0; bus.ser_in = 1'b0; bus.ser_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 32'(bus.data_out), 32'h00);
        check("rst_sel", 32'(bus.sel_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pulses", 32'({bus.frame_valid, bus.parity_err, bus.timeout_err}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Good frame, even parity
        f = {1'b1, 8'hA5, 1'b1};
        start_frame(); send_bits(f, 10, 0, 0); finish_frame("good_a5", f);

        // Bad parity: outputs must hold A5/1
        f = {1'b0, 8'h3C, 1'b1};
        start_frame(); send_bits(f, 10, 0, 0); finish_frame("bad_3c", f);

        // Timeout after 4 bits
        clear_pulse_counts();
        start_frame(); send_bits({1'b1, 8'h00, 1'b0}, 4, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15 || k == 16) begin
                check($sformatf("to_err_idle%0d", k), 32'(bus.timeout_err), 32'(k == 16));
                check($sformatf("to_busy_idle%0d", k), 32'(bus.busy), 32'(k != 16));
            end
        end
        tick();
        check("to_pulse_count", 32'(cnt_to), 32'd1);
        check("to_data_hold", 32'(bus.data_out), 32'(exp_data));
        check("to_sel_hold", 32'(bus.sel_out), 32'(exp_sel));

        // Restart after 5 bits
        clear_pulse_counts();
        start_frame(); send_bits({1'b1, 8'h55, 1'b0}, 5, 0, 0);
        f = {1'b0, 8'hFF, 1'b0};
        start_frame(); send_bits(f, 10, 0, 0); finish_frame("restart_ff", f);
        check("restart_fv_count", 32'(cnt_fv), 32'd1);
        check("restart_err_count", 32'(cnt_pe + cnt_to), 32'd0);

        // frame_start priority over ser_valid, then gapped frame
        f = {1'b1, 8'h01, 1'b0};
        bus.frame_start = 1'b1; bus.ser_valid = 1'b1; bus.ser_in = 1'b1;
        tick();
        bus.frame_start = 1'b0; bus.ser_valid = 1'b0;
        send_bits(f, 10, 1, 3); finish_frame("gap_01", f);

        // Randomized frames, half with corrupted parity
        clear_pulse_counts();
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       m;
            logic       p;
            d = 8'($urandom);
            m = 1'($urandom);
            p = ^{m, d};
            if ($urandom_range(1, 0) == 1) p = ~p;
            f = {m, d, p};
            start_frame(); send_bits(f, 10, 0, 2);
            finish_frame($sformatf("rand%0d", n), f);
        end
        check("rand_no_timeout", 32'(cnt_to), 32'd0);

        // Asynchronous reset in the middle of a frame
        start_frame(); send_bits({1'b1, 8'hC3, 1'b0}, 3, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_data = 8'h00; exp_sel = 1'b0;
        check("midrst_data", 32'(bus.data_out), 32'(exp_data));
        check("midrst_sel", 32'(bus.sel_out), 32'(exp_sel));
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_pulse_counts();
        repeat (20) tick();
        check("midrst_no_pulses", 32'(cnt_fv + cnt_pe + cnt_to), 32'd0);
        check("midrst_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
